// File: rtl/ask2_sample_capture_writer_if.sv
// Write-side bus of the single-port on-chip data RAM (s2 port).
// The master drives every signal; the RAM (or a bench) observes through the slave view.
interface ask2_sample_capture_writer_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic                mem_clken;

  modport master (
    output mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, mem_clken
  );

  modport slave (
    input mem_address, mem_byteenable, mem_chipselect,
          mem_write, mem_writedata, mem_clken
  );
endinterface

// File: rtl/ask2_sample_capture_writer.sv
// Packs a 16-bit sample stream two-per-word and writes it into the data RAM,
// either once until full or circularly with wrap-around.
module ask2_sample_capture_writer #(
  parameter int DEPTH    = 2024,
  parameter int ADDR_W   = 11,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                circular,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_data,
  ask2_sample_capture_writer_if.master mem,
  output logic                busy,
  output logic                done,
  output logic                wrapped,
  output logic [ADDR_W-1:0]   wr_ptr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     wr_ptr_reg, wr_ptr_next;
  logic                  pending_reg, pending_next;
  logic [SAMPLE_W-1:0]   held_reg, held_next;
  logic                  circ_reg, circ_next;
  logic                  wrapped_reg, wrapped_next;
  logic                  done_reg, done_next;
  logic                  mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0]     mem_addr_reg, mem_addr_next;
  logic [2*SAMPLE_W-1:0] mem_data_reg, mem_data_next;
  logic [3:0]            mem_be_reg, mem_be_next;

  logic [ADDR_W-1:0]     adv_ptr;
  logic                  adv_wrap;
  logic                  adv_full;
  logic                  pend;

  // Pointer step after a write: wrap in circular mode, park on the last word otherwise.
  always_comb begin
    adv_ptr  = wr_ptr_reg + 1'b1;
    adv_wrap = 1'b0;
    adv_full = 1'b0;
    if (wr_ptr_reg == LAST_ADDR) begin
      if (circ_reg) begin
        adv_ptr  = '0;
        adv_wrap = 1'b1;
      end else begin
        adv_ptr  = wr_ptr_reg;
        adv_full = 1'b1;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    pending_next   = pending_reg;
    held_next      = held_reg;
    circ_next      = circ_reg;
    wrapped_next   = wrapped_reg;
    done_next      = 1'b0;
    mem_write_next = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_data_next  = mem_data_reg;
    mem_be_next    = 4'b0000;
    pend           = pending_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next   = RUN;
          wr_ptr_next  = '0;
          pending_next = 1'b0;
          wrapped_next = 1'b0;
          circ_next    = circular;
        end
      end

      RUN: begin
        if (sample_valid) begin
          if (!pending_reg) begin
            held_next = sample_data;
            pend      = 1'b1;
          end else begin
            mem_write_next = 1'b1;
            mem_addr_next  = wr_ptr_reg;
            mem_data_next  = {sample_data, held_reg};
            mem_be_next    = 4'b1111;
            pend           = 1'b0;
            wr_ptr_next    = adv_ptr;
            if (adv_wrap) wrapped_next = 1'b1;
            if (adv_full) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
        pending_next = pend;
        // stop sees the pending flag after this cycle's sample has been packed
        if (stop && state_next == RUN) begin
          if (pend) begin
            state_next = FLUSH;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      FLUSH: begin
        mem_write_next = 1'b1;
        mem_addr_next  = wr_ptr_reg;
        mem_data_next  = {{SAMPLE_W{1'b0}}, held_reg};
        mem_be_next    = 4'b0011;
        pending_next   = 1'b0;
        wr_ptr_next    = adv_ptr;
        if (adv_wrap) wrapped_next = 1'b1;
        done_next      = 1'b1;
        state_next     = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      pending_reg   <= 1'b0;
      held_reg      <= '0;
      circ_reg      <= 1'b0;
      wrapped_reg   <= 1'b0;
      done_reg      <= 1'b0;
      mem_write_reg <= 1'b0;
      mem_addr_reg  <= '0;
      mem_data_reg  <= '0;
      mem_be_reg    <= 4'b0000;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      pending_reg   <= pending_next;
      held_reg      <= held_next;
      circ_reg      <= circ_next;
      wrapped_reg   <= wrapped_next;
      done_reg      <= done_next;
      mem_write_reg <= mem_write_next;
      mem_addr_reg  <= mem_addr_next;
      mem_data_reg  <= mem_data_next;
      mem_be_reg    <= mem_be_next;
    end
  end

  assign mem.mem_address    = mem_addr_reg;
  assign mem.mem_byteenable = mem_be_reg;
  assign mem.mem_chipselect = mem_write_reg;
  assign mem.mem_write      = mem_write_reg;
  assign mem.mem_writedata  = mem_data_reg;
  assign mem.mem_clken      = 1'b1;

  assign busy    = (state_reg != IDLE);
  assign done    = done_reg;
  assign wrapped = wrapped_reg;
  assign wr_ptr  = wr_ptr_reg;

endmodule

// File: tb/tb_ask2_sample_capture_writer.sv
// Randomized scoreboard bench for the sample capture writer: a sample-count
// reference model predicts every RAM write and done pulse; a monitor checks them.
module tb_ask2_sample_capture_writer;
  localparam int DEPTH = 2024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        circular = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic        busy, done, wrapped;
  logic [10:0] wr_ptr;

  ask2_sample_capture_writer_if mem_if ();

  ask2_sample_capture_writer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .circular     (circular),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .mem          (mem_if),
    .busy         (busy),
    .done         (done),
    .wrapped      (wrapped),
    .wr_ptr       (wr_ptr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        wr;
    logic [10:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        dn;
  } exp_t;

  exp_t expq[$];

  // Reference model: capture described by the count of accepted samples.
  bit          active   = 0;
  bit          flushing = 0;
  bit          mcirc    = 0;
  bit          wrap_exp = 0;
  int          n        = 0;
  int          words    = 0;
  logic [15:0] prev     = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int exp_ptr();
    if (mcirc) return words % DEPTH;
    return (words > DEPTH - 1) ? DEPTH - 1 : words;
  endfunction

  function automatic void push(input bit wr, input int addr, input logic [31:0] data,
                               input logic [3:0] be, input bit dn);
    exp_t e;
    e.wr   = wr;
    e.addr = 11'(addr);
    e.data = data;
    e.be   = be;
    e.dn   = dn;
    expq.push_back(e);
    if (wr) begin
      words++;
      if (mcirc && addr == DEPTH - 1) wrap_exp = 1;
    end
  endfunction

  function automatic int word_addr(input int w);
    return mcirc ? (w % DEPTH) : w;
  endfunction

  // Predicts the DUT's response to the inputs presented for the coming edge.
  task automatic model_step(input bit st, input bit sp, input bit ci, input bit v,
                            input logic [15:0] d);
    bit ended;
    int w;
    ended = 0;
    if (flushing) begin
      push(1, word_addr((n - 1) / 2), {16'h0000, prev}, 4'b0011, 1);
      flushing = 0;
      active   = 0;
    end else if (!active) begin
      if (st) begin
        active   = 1;
        n        = 0;
        words    = 0;
        mcirc    = ci;
        wrap_exp = 0;
      end
    end else begin
      if (v) begin
        n++;
        if (n % 2 == 0) begin
          w     = n / 2 - 1;
          ended = (!mcirc && w == DEPTH - 1) || sp;
          push(1, word_addr(w), {d, prev}, 4'b1111, ended);
          if (ended) active = 0;
        end else begin
          prev = d;
        end
      end
      if (sp && !ended) begin
        if (n % 2 == 1) flushing = 1;
        else begin
          push(0, 0, 32'h0, 4'h0, 1);
          active = 0;
        end
      end
    end
  endtask

  // One clock of stimulus; state expectations from the previous edge are checked first.
  task automatic cycle(input bit st, input bit sp, input bit ci, input bit v,
                       input logic [15:0] d);
    @(negedge clk);
    chk("busy", busy, active || flushing);
    chk("wrapped", wrapped, wrap_exp);
    chk("wr_ptr", wr_ptr, exp_ptr());
    start        = st;
    stop         = sp;
    circular     = ci;
    sample_valid = v;
    sample_data  = d;
    model_step(st, sp, ci, v, d);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, 16'h0);
  endtask

  task automatic check_reset_values();
    chk("rst_mem_write", mem_if.mem_write, 0);
    chk("rst_chipselect", mem_if.mem_chipselect, 0);
    chk("rst_byteenable", mem_if.mem_byteenable, 0);
    chk("rst_address", mem_if.mem_address, 0);
    chk("rst_writedata", mem_if.mem_writedata, 0);
    chk("rst_clken", mem_if.mem_clken, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_wr_ptr", wr_ptr, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset        = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    sample_valid = 1'b0;
    expq.delete();
    active   = 0;
    flushing = 0;
    mcirc    = 0;
    wrap_exp = 0;
    n        = 0;
    words    = 0;
    #1;
    check_reset_values();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_hold_write", mem_if.mem_write, 0);
      chk("rst_hold_ptr", wr_ptr, 0);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: every write strobe or done pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cs_eq_write", mem_if.mem_chipselect, mem_if.mem_write);
      if (mem_if.mem_write || done) begin
        if (expq.size() == 0) begin
          chk("unexpected_event", {mem_if.mem_write, done}, 2'b00);
        end else begin
          exp_t e;
          e = expq.pop_front();
          $display("txn wr=%b addr=%0d data=%h be=%h done=%b", mem_if.mem_write,
                   mem_if.mem_address, mem_if.mem_writedata, mem_if.mem_byteenable, done);
          chk("write_done_flags", {mem_if.mem_write, done}, {e.wr, e.dn});
          if (e.wr)
            chk("write_payload",
                {mem_if.mem_address, mem_if.mem_writedata, mem_if.mem_byteenable},
                {e.addr, e.data, e.be});
        end
      end
    end
  end

  initial begin
    int cnt;
    #12;
    check_reset_values();
    @(negedge clk);
    reset = 1'b0;

    // Two full words, samples spaced out, then a stop with nothing pending
    cycle(1, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'h1111);
    cycle(0, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'h2222);
    cycle(0, 0, 0, 1, 16'h3333);
    cycle(0, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'h4444);
    idle(2);
    chk("wr_ptr_after_4", wr_ptr, 2);
    cycle(0, 1, 0, 0, 16'h0);
    idle(2);

    // Odd sample count then stop: half-word flush
    cycle(1, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'h000A);
    cycle(0, 0, 0, 1, 16'h000B);
    cycle(0, 0, 0, 1, 16'h000C);
    cycle(0, 1, 0, 0, 16'h0);
    idle(3);
    chk("busy_after_flush", busy, 0);

    // stop with the completing sample, and start ignored while running
    cycle(1, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'h5555);
    cycle(0, 0, 0, 1, 16'h6666);
    cycle(1, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'h7777);
    cycle(0, 1, 0, 1, 16'h8888);
    idle(3);

    // Reset in the middle of a capture
    cycle(1, 0, 0, 0, 16'h0);
    cycle(0, 0, 0, 1, 16'h0101);
    cycle(0, 0, 0, 1, 16'h0202);
    cycle(0, 0, 0, 1, 16'h0303);
    do_reset();
    idle(2);

    // Single-shot fill: stops at the last word, later samples ignored
    cycle(1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 2 * DEPTH + 10; i++) cycle(0, 0, 0, 1, 16'($urandom));
    idle(3);
    chk("single_wr_ptr", wr_ptr, DEPTH - 1);
    chk("single_wrapped", wrapped, 0);
    chk("single_busy", busy, 0);

    // Circular fill past the end with gaps
    cycle(1, 0, 1, 0, 16'h0);
    cnt = 0;
    while (cnt < 2 * DEPTH + 2) begin
      if ($urandom_range(0, 9) < 8) begin
        cycle(0, 0, 0, 1, 16'($urandom));
        cnt++;
      end else begin
        cycle(0, 0, 0, 0, 16'h0);
      end
    end
    idle(2);
    chk("circ_busy", busy, 1);
    chk("circ_wrapped", wrapped, 1);
    chk("circ_wr_ptr", wr_ptr, 1);
    cycle(0, 1, 0, 0, 16'h0);
    idle(3);
    chk("circ_busy_after_stop", busy, 0);

    // Random control mix
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0, 1'($urandom),
            $urandom_range(0, 9) < 7, 16'($urandom));
    cycle(0, 1, 0, 0, 16'h0);
    idle(4);
    chk("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ask2_sample_capture_writer.md
Name: ask2_sample_capture_writer

Overview:
Upstream feeder for the Nios on-chip data RAM (32-bit, 11-bit word address, 2024 words, byte enables, single port). Accepts a 16-bit sample stream, packs two samples per 32-bit word, and issues single-cycle writes on the RAM's s2 port. The CPU reads the captured buffer on s1. Supports single-shot capture (stop when full) and circular capture (wrap-around).

Parameters:
DEPTH, 2024, number of 32-bit words in the target RAM; last address DEPTH-1
ADDR_W, 11, word address width
SAMPLE_W, 16, sample width; fixed at half of the 32-bit data word

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; arms capture from address 0
stop  in  1  one-cycle pulse; ends capture, flushes pending half-word
circular  in  1  sampled at start: 1 = wrap at DEPTH-1, 0 = stop when full
sample_valid  in  1  sample_data valid this cycle
sample_data  in  16  sample
mem_address  out  11  RAM word address
mem_byteenable  out  4  RAM byte enables
mem_chipselect  out  1  RAM chipselect
mem_write  out  1  RAM write strobe
mem_writedata  out  32  RAM write data
mem_clken  out  1  RAM clock enable; tied 1
busy  out  1  capture active (RUN or FLUSH)
done  out  1  one-cycle pulse when capture ends
wrapped  out  1  sticky; set on first wrap in circular mode, cleared on start
wr_ptr  out  11  next word address to be written

Behaviour:
- Reset (async assert): state IDLE; mem_address=0, mem_byteenable=0, mem_chipselect=0, mem_write=0, mem_writedata=0, busy=0, done=0, wrapped=0, wr_ptr=0, half-word pending flag=0, latched circular mode=0. mem_clken=1 always. A write pending at reset is dropped.
- All mem_* outputs registered; mem_chipselect equals mem_write (both high exactly one cycle per write). RAM has no waitrequest; every write completes in its strobe cycle.
- States: IDLE, RUN, FLUSH.
- IDLE: sample_valid, stop ignored. start -> RUN next cycle; wr_ptr=0, pending=0, wrapped=0, circular latched.
- RUN, sample_valid with pending=0: sample held as low half (bits 15:0); pending=1; no write.
- RUN, sample_valid with pending=1: next cycle mem_write=1, mem_address=wr_ptr, mem_writedata={new sample, held sample}, mem_byteenable=4'b1111; pending=0; wr_ptr advances.
- Latency: the write strobe occurs the cycle after the completing sample is accepted.
- wr_ptr advance: wr_ptr+1, except at DEPTH-1 (2023): circular=1 -> wr_ptr=0, wrapped=1, stay RUN; circular=0 -> wr_ptr stays 2023 (next unwritten address is past end), done pulse in same cycle as the write, -> IDLE. Addresses 2024-2047 are never driven.
- RUN, stop: -> FLUSH if pending=1, else -> IDLE with done pulse next cycle.
- stop and sample_valid in same cycle: sample accepted first (packing rules apply), then stop evaluated with the updated pending flag.
- FLUSH: one write cycle, mem_writedata={16'h0000, held sample}, mem_byteenable=4'b0011, mem_address=wr_ptr; wr_ptr advances (wrap rules as above); done pulse same cycle; -> IDLE. Samples arriving in FLUSH are dropped.
- start while RUN/FLUSH ignored.
- busy=1 in RUN and FLUSH, 0 in IDLE.

Test Plan:
- Reset mid-RUN after 3 samples -> all outputs at reset values, no mem_write for 10 cycles, wr_ptr=0.
- start(circular=0), samples 0x1111,0x2222,0x3333,0x4444 -> writes addr0=0x22221111, addr1=0x44443333, byteenable=F, each strobe one cycle after the 2nd sample; wr_ptr=2.
- start, 3 samples 0xA,0xB,0xC, then stop -> addr0=0x000B000A (be=F), then FLUSH write addr1=0x0000000C be=0011, done pulse, busy=0.
- circular=0, 4048 samples -> last write at addr 2023, done in that cycle, IDLE; further samples produce no writes; wrapped=0.
- circular=1, 4050 samples -> write at 2023 then addr 0 = {s4050,s4049}; wrapped=1; busy stays 1 until stop.
- stop in same cycle as 2nd sample -> full-word write be=F, no FLUSH write, done pulse; start during RUN has no effect on wr_ptr.
